simon_sequence_gen: RTL and testbench

Parametrised pattern generator and player for the memory-game datapath. It owns a free-running Galois LFSR and a DEPTH-entry symbol store. On request it fills the store with one pseudo-random symbol per cycle. It then replays any prefix of the stored pattern to the LED/tone driver over a valid/ready stream, and gives the input checker random read access to stored symbols.

---
 rtl/simon_sequence_gen.sv | 118 +++++++++++
 tb/tb_simon_sequence_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequence_gen.sv
// simon_sequence_gen: free-running LFSR feeding a DEPTH-entry symbol store with fill, valid/ready replay and random read.
// Define SIMON_NO_REPEAT_EN to forbid equal adjacent symbols during fill.
module simon_sequence_gen #(
   parameter int          SYM_W = 2,
   parameter int          DEPTH = 100,
   parameter logic [31:0] SEED  = 32'hACE1_2468,
   localparam int         LEN_W = $clog2(DEPTH+1),
   localparam int         IW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gen_start,
   output logic             busy,
   output logic             seq_valid,
   input  logic             play_start,
   input  logic [LEN_W-1:0] play_len,
   output logic             play_valid,
   input  logic             play_ready,
   output logic [SYM_W-1:0] play_sym,
   output logic             play_done,
   input  logic [IW-1:0]    rd_idx,
   output logic [SYM_W-1:0] rd_sym
);
   localparam logic [31:0] POLY   = 32'h8020_0003;
   localparam logic [31:0] SEED_I = (SEED == 32'd0) ? 32'd1 : SEED;

   typedef enum logic [1:0] {IDLE, FILL, READY, PLAY} state_t;

   state_t state, state_n;
   logic [31:0] lfsr;
   logic [IW-1:0] idx, idx_n;
   logic [LEN_W-1:0] len, len_n, clamp;
   logic done_n, we;
   logic [SYM_W-1:0] cand, wdata;
   logic [SYM_W-1:0] store [DEPTH];

   assign cand = lfsr[SYM_W-1:0];
   assign clamp = (play_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : play_len;

`ifdef SIMON_NO_REPEAT_EN
   logic [SYM_W-1:0] prev;
   // Entry 0 has no predecessor, so it is always stored raw.
   assign wdata = (idx != '0 && cand == prev) ? cand + 1'b1 : cand;
   always_ff @(posedge clk or posedge rst)
      if (rst)
         prev <= '0;
      else if (we)
         prev <= wdata;
`else
   assign wdata = cand;
`endif

   always_comb begin
      state_n = state;
      idx_n = idx;
      len_n = len;
      done_n = 1'b0;
      we = 1'b0;
      if (gen_start) begin
         state_n = FILL;
         idx_n = '0;
      end else begin
         case (state)
            FILL: begin
               we = 1'b1;
               idx_n = idx + 1'b1;
               if (idx == IW'(DEPTH-1)) begin
                  state_n = READY;
                  idx_n = '0;
               end
            end
            READY:
               if (play_start) begin
                  done_n = (clamp == '0);
                  state_n = (clamp == '0) ? READY : PLAY;
                  idx_n = '0;
                  len_n = clamp;
               end
            PLAY:
               if (play_ready) begin
                  idx_n = idx + 1'b1;
                  if (LEN_W'(idx) == len - 1'b1) begin
                     state_n = READY;
                     done_n = 1'b1;
                  end
               end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         lfsr <= SEED_I;
         idx <= '0;
         len <= '0;
         play_done <= 1'b0;
         rd_sym <= '0;
      end else begin
         state <= state_n;
         lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
         idx <= idx_n;
         len <= len_n;
         play_done <= done_n;
         // Write-first: a same-cycle write to the read index is forwarded.
         rd_sym <= (we && rd_idx == idx) ? wdata : (32'(rd_idx) < DEPTH) ? store[rd_idx] : '0;
      end

   always_ff @(posedge clk)
      if (we)
         store[idx] <= wdata;

   assign busy = (state == FILL);
   assign seq_valid = (state == READY) || (state == PLAY);
   assign play_valid = (state == PLAY);
   assign play_sym = play_valid ? store[idx] : '0;
endmodule

// File: tb/tb_simon_sequence_gen.sv
// tb_simon_sequence_gen: directed and table-driven checks of fill, replay, abort and reset,
// plus an adjacent-repeat property check on a DEPTH=100 instance.
module tb_simon_sequence_gen;
   localparam logic [31:0] SEED = 32'hACE1_2468;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic gen_start = 1'b0, play_start = 1'b0, play_ready = 1'b1;
   logic [3:0] play_len = '0;
   logic [2:0] rd_idx = '0;
   logic busy, seq_valid, play_valid, play_done;
   logic [1:0] play_sym, rd_sym;

   logic g1 = 1'b0;
   logic [6:0] rd1 = '0;
   logic b1, sv1, pv1, pd1;
   logic [1:0] ps1, rs1;

   int tests = 0, failed = 0;
   int cyc = 0;
   logic [31:0] m;
   logic [1:0] hist [0:32767];
   logic [1:0] exp_pat [8];

   always #5 clk = ~clk;

   simon_sequence_gen #(.SYM_W(2), .DEPTH(8), .SEED(SEED)) u0 (
      .clk(clk), .rst(rst), .gen_start(gen_start), .busy(busy), .seq_valid(seq_valid),
      .play_start(play_start), .play_len(play_len), .play_valid(play_valid),
      .play_ready(play_ready), .play_sym(play_sym), .play_done(play_done),
      .rd_idx(rd_idx), .rd_sym(rd_sym));

   simon_sequence_gen #(.SYM_W(2), .DEPTH(100), .SEED(SEED)) u1 (
      .clk(clk), .rst(rst), .gen_start(g1), .busy(b1), .seq_valid(sv1),
      .play_start(1'b0), .play_len(7'd0), .play_valid(pv1),
      .play_ready(1'b1), .play_sym(ps1), .play_done(pd1),
      .rd_idx(rd1), .rd_sym(rs1));

   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Reference LFSR: hist[c] is the symbol source seen during cycle c.
   always @(posedge clk) begin
      hist[cyc] <= m[1:0];
      m <= rst ? SEED : lfsr_next(m);
      cyc <= cyc + 1;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Called in cycle c+1 after gen_start was sampled at the end of cycle c.
   task automatic fill_finish(input int c);
      int nb, nd;
      logic [1:0] wf;
      logic [1:0] raw;
      nb = 0;
      nd = 0;
      wf = 'x;
      for (int t = 0; t < 20; t++) begin
         if (cyc == c + 4) wf = rd_sym;
         if (play_done) nd++;
         if (busy) nb++;
         if (!busy && nb > 0) break;
         step;
      end
      chk("busy_len", nb, 8);
      chk("seq_valid_rise", seq_valid, 1);
      chk("fill_no_done", nd, 0);
      for (int k = 0; k < 8; k++) begin
         raw = hist[c + 1 + k];
`ifdef SIMON_NO_REPEAT_EN
         if (k > 0 && raw == exp_pat[k-1]) raw = raw + 2'd1;
`endif
         exp_pat[k] = raw;
      end
      chk("write_first", wf, exp_pat[2]);
      for (int k = 0; k < 8; k++) begin
         rd_idx = 3'(k);
         step;
         chk($sformatf("fill_entry%0d", k), rd_sym, exp_pat[k]);
      end
   endtask

   task automatic do_fill;
      int c;
      c = cyc;
      rd_idx = 3'd2;
      gen_start = 1'b1;
      step;
      gen_start = 1'b0;
      fill_finish(c);
   endtask

   typedef struct {
      logic [3:0] len;
      logic [7:0] mask;
      int         exp_n;
   } vec_t;

   task automatic play_run(input vec_t v, input int id);
      int acc, nd, done_at, bad_sym, unstable;
      logic [1:0] last;
      logic stalled;
      acc = 0; nd = 0; done_at = -1; bad_sym = 0; unstable = 0; stalled = 1'b0; last = '0;
      play_len = v.len;
      play_start = 1'b1;
      step;
      play_start = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (play_done) begin
            nd++;
            done_at = acc;
         end
         play_ready = v.mask[t % 8];
         if (play_valid) begin
            if (stalled && play_sym !== last) unstable++;
            if (acc >= v.exp_n) bad_sym++;
            else if (play_sym !== exp_pat[acc]) bad_sym++;
            last = play_sym;
            stalled = !play_ready;
            if (play_ready) acc++;
         end else
            stalled = 1'b0;
         step;
      end
      play_ready = 1'b1;
      chk($sformatf("v%0d_accepts", id), acc, v.exp_n);
      chk($sformatf("v%0d_done_count", id), nd, 1);
      chk($sformatf("v%0d_done_after_last", id), done_at, v.exp_n);
      chk($sformatf("v%0d_symbols", id), bad_sym, 0);
      chk($sformatf("v%0d_stall_stable", id), unstable, 0);
      chk($sformatf("v%0d_back_ready", id), {busy, seq_valid, play_valid}, 3'b010);
   endtask

   vec_t vecs [6];

   initial begin
      int c, acc, rep, tmo;
      logic found;
      logic [1:0] prev;
      vecs[0] = '{4'd5,  8'hFF, 5};
      vecs[1] = '{4'd5,  8'h99, 5};
      vecs[2] = '{4'd0,  8'hFF, 0};
      vecs[3] = '{4'd12, 8'hFF, 8};
      vecs[4] = '{4'd8,  8'hAA, 8};
      vecs[5] = '{4'd1,  8'hFF, 1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {busy, seq_valid, play_valid, play_sym, play_done, rd_sym}, 8'h00);
      rst = 1'b0;
      step;
      chk("idle_seq_valid", seq_valid, 0);

      do_fill;
      for (int i = 0; i < 6; i++) play_run(vecs[i], i);

      // Abort a replay while symbol 3 is presented.
      acc = 0;
      found = 1'b0;
      play_len = 4'd8;
      play_ready = 1'b1;
      play_start = 1'b1;
      step;
      play_start = 1'b0;
      c = cyc;
      for (int t = 0; t < 20; t++) begin
         if (play_valid && acc == 3) begin
            chk("abort_sym3", play_sym, exp_pat[3]);
            found = 1'b1;
            c = cyc;
            gen_start = 1'b1;
            rd_idx = 3'd2;
            break;
         end
         if (play_valid) acc++;
         step;
      end
      chk("abort_reached", found, 1);
      step;
      gen_start = 1'b0;
      chk("abort_valid_drop", {play_valid, busy}, 2'b01);
      fill_finish(c);

      // Reset while the fill is at index 4.
      rd_idx = 3'd1;
      gen_start = 1'b1;
      step;
      gen_start = 1'b0;
      repeat (4) step;
      rst = 1'b1;
      #1;
      chk("midfill_rst_outputs", {busy, seq_valid, play_valid, play_sym, play_done, rd_sym}, 8'h00);
      step;
      rst = 1'b0;
      play_len = 4'd3;
      play_start = 1'b1;
      step;
      play_start = 1'b0;
      step;
      chk("midfill_rst_idle", {busy, seq_valid, play_valid, play_done}, 4'b0000);

      do_fill;
      play_run(vecs[0], 6);

      // Adjacent-repeat property across 50 DEPTH=100 regenerations.
      rep = 0;
      tmo = 0;
      for (int g = 0; g < 50; g++) begin
         g1 = 1'b1;
         step;
         g1 = 1'b0;
         for (int t = 0; t < 200 && !sv1; t++) step;
         if (!sv1) tmo++;
         rd1 = 7'd0;
         step;
         prev = rs1;
         for (int k = 1; k < 100; k++) begin
            rd1 = 7'(k);
            step;
            if (rs1 == prev) rep++;
            prev = rs1;
         end
      end
      chk("d100_fill_timeouts", tmo, 0);
`ifdef SIMON_NO_REPEAT_EN
      chk("d100_adjacent_repeats", rep, 0);
`else
      chk("d100_has_repeat", (rep > 0), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
